deser_arbiter: RTL and testbench

DESER_ARBITER -- requirements
Module: deser_arbiter

---
 rtl/deser_arbiter.sv | 106 ++++++++++
 tb/tb_deser_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/deser_arbiter.sv
// Round-robin arbiter: grants one serial requester for a full frame and
// forwards its bit stream, one cycle late, to a shared deserializer.
module deser_arbiter #(
    parameter int unsigned REQ_NUM   = 4,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [REQ_NUM-1:0]         req_i,
    input  logic [REQ_NUM-1:0]         data_i,
    input  logic [REQ_NUM-1:0]         data_val_i,
    output logic [REQ_NUM-1:0]         gnt_o,
    output logic                       ser_data_o,
    output logic                       ser_data_val_o,
    output logic [$clog2(REQ_NUM)-1:0] src_id_o,
    output logic                       frame_done_o,
    output logic                       busy_o
);

    localparam int unsigned ID_W  = $clog2(REQ_NUM);
    localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(REQ_NUM - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;
    logic             win_found;
    logic [ID_W-1:0]  win_idx;
    int unsigned      cand;
    logic             cur_bit;
    logic             cur_val;

    assign cur_bit = data_i[src_id_o];
    assign cur_val = data_val_i[src_id_o];

    // First requester at or above ptr, wrapping past REQ_NUM-1 back to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= REQ_NUM) begin
                cand = cand - REQ_NUM;
            end
            if (!win_found && req_i[ID_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(cand);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            ptr            <= '0;
            cnt            <= '0;
            gnt_o          <= '0;
            src_id_o       <= '0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            frame_done_o   <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    ser_data_o     <= 1'b0;
                    ser_data_val_o <= 1'b0;
                    if (win_found) begin
                        state    <= GRANT;
                        gnt_o    <= REQ_NUM'(1) << win_idx;
                        src_id_o <= win_idx;
                        busy_o   <= 1'b1;
                        cnt      <= '0;
                    end
                end
                GRANT: begin
                    ser_data_o     <= cur_bit;
                    ser_data_val_o <= cur_val;
                    // Grant is released only by the last valid bit, never by req_i.
                    if (cur_val) begin
                        if (cnt == CNT_LAST) begin
                            frame_done_o <= 1'b1;
                            state        <= IDLE;
                            gnt_o        <= '0;
                            busy_o       <= 1'b0;
                            cnt          <= '0;
                            ptr          <= (src_id_o == ID_LAST) ? '0 : src_id_o + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deser_arbiter.sv
// Directed plus randomized bench for deser_arbiter, checked cycle by cycle
// against a transaction-level reference model.
module tb_deser_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned FL = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req   = '0;
    logic [N-1:0] dat   = '0;
    logic [N-1:0] dval  = '0;
    logic [N-1:0] gnt;
    logic         ser;
    logic         ser_val;
    logic [1:0]   src;
    logic         done;
    logic         busy;

    deser_arbiter #(.REQ_NUM(N), .FRAME_LEN(FL)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .req_i         (req),
        .data_i        (dat),
        .data_val_i    (dval),
        .gnt_o         (gnt),
        .ser_data_o    (ser),
        .ser_data_val_o(ser_val),
        .src_id_o      (src),
        .frame_done_o  (done),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the link, how many valid bits it has sent,
    // and where the next search starts.
    int           m_owner = -1;
    int           m_bits  = 0;
    int           m_ptr   = 0;
    logic [N-1:0] e_gnt   = '0;
    logic         e_ser   = 1'b0;
    logic         e_val   = 1'b0;
    logic         e_done  = 1'b0;
    logic         e_busy  = 1'b0;
    logic [1:0]   e_src   = '0;

    logic [FL-1:0] cap;
    int            n_val;
    int            n_done;
    bit            force3 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_bits  = 0;
        m_ptr   = 0;
        e_gnt   = '0;
        e_ser   = 1'b0;
        e_val   = 1'b0;
        e_done  = 1'b0;
        e_busy  = 1'b0;
        e_src   = '0;
    endtask

    // Applies the rules to the inputs present at the clock edge.
    task automatic model_edge();
        int c;
        e_done = 1'b0;
        if (m_owner < 0) begin
            e_ser = 1'b0;
            e_val = 1'b0;
            for (int k = 0; k < int'(N); k++) begin
                c = (m_ptr + k) % int'(N);
                if (m_owner < 0 && req[c]) begin
                    m_owner = c;
                    m_bits  = 0;
                    e_src   = 2'(c);
                end
            end
        end else begin
            e_ser = dat[m_owner];
            e_val = dval[m_owner];
            if (dval[m_owner]) begin
                m_bits++;
                if (m_bits == int'(FL)) begin
                    e_done  = 1'b1;
                    m_ptr   = (m_owner + 1) % int'(N);
                    m_owner = -1;
                end
            end
        end
        e_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e_busy = (m_owner >= 0);
    endtask

    task automatic check_outputs();
        chk("gnt_o", 32'(gnt), 32'(e_gnt));
        chk("src_id_o", 32'(src), 32'(e_src));
        chk("ser_data_o", 32'(ser), 32'(e_ser));
        chk("ser_data_val_o", 32'(ser_val), 32'(e_val));
        chk("frame_done_o", 32'(done), 32'(e_done));
        chk("busy_o", 32'(busy), 32'(e_busy));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (ser_val === 1'b1) begin
            cap = {cap[FL-2:0], ser};
            n_val++;
        end
        if (done === 1'b1) n_done++;
    endtask

    task automatic rand_foreign();
        dat  = N'($urandom);
        dval = N'($urandom);
        if (force3) dval[3] = 1'b1;
    endtask

    task automatic frame(input int o, input logic [FL-1:0] w, input int gap_at,
                         input int gap_len, input int drop_at);
        cap    = '0;
        n_val  = 0;
        n_done = 0;
        rand_foreign();
        step();
        chk("grant_onehot", 32'(gnt), 32'(1) << o);
        chk("grant_src", 32'(src), 32'(o));
        for (int i = 0; i < int'(FL); i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    rand_foreign();
                    dval[o] = 1'b0;
                    step();
                    chk("gap_hold_nvalid", 32'(n_val), 32'(i));
                    chk("gap_no_done", 32'(n_done), 32'd0);
                end
            end
            if (i == drop_at) req[o] = 1'b0;
            rand_foreign();
            dat[o]  = w[FL-1-i];
            dval[o] = 1'b1;
            step();
            if (i < int'(FL) - 1) chk("grant_held", 32'(gnt), 32'(1) << o);
        end
        chk("frame_word", 32'(cap), 32'(w));
        chk("frame_nvalid", 32'(n_val), 32'(FL));
        chk("frame_done_count", 32'(n_done), 32'd1);
        chk("frame_end_gnt", 32'(gnt), 32'd0);
        chk("frame_end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        // Asynchronous reset with the clock still low.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin from ptr = 0 with every requester asking.
        req = 4'b1111;
        frame(0, 16'h1234, -1, 0, -1);
        frame(1, 16'hBEEF, -1, 0, -1);
        frame(2, 16'h0F0F, -1, 0, -1);
        frame(3, 16'hC001, -1, 0, -1);

        // Single frame from requester 2.
        req = 4'b0100;
        frame(2, 16'hA5C3, -1, 0, -1);

        // ptr now 3: requester 3 then wrap to 0.
        req = 4'b1001;
        frame(3, 16'h5A5A, -1, 0, -1);
        frame(0, 16'h8001, -1, 0, -1);

        // Three invalid cycles after bit 5.
        req = 4'b0010;
        frame(1, 16'h6C39, 5, 3, -1);

        // Request dropped after bit 8 while requester 3 streams valid bits.
        req    = 4'b0001;
        force3 = 1'b1;
        frame(0, 16'h00FF, -1, 0, 8);
        force3 = 1'b0;

        // Reset pulsed between edges after bit 10 of a frame.
        req    = 4'b0100;
        n_done = 0;
        rand_foreign();
        step();
        chk("rst_pre_grant", 32'(gnt), 32'h4);
        for (int i = 0; i < 10; i++) begin
            rand_foreign();
            dval[2] = 1'b1;
            step();
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_no_done", 32'(n_done), 32'd0);
        rst_n = 1'b1;
        req   = 4'b0010;
        frame(1, 16'h3C96, -1, 0, -1);

        // Randomized traffic.
        req = 4'b0000;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) req = N'($urandom);
            dat  = N'($urandom);
            dval = N'($urandom) | N'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
